// File: rtl/avalon_bus_arbiter_if.sv
// Shared-slave arbiter bus bundle: per-master command ports,
// muxed slave command, and grant status.
interface avalon_bus_arbiter_if #(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_W      = 30
);
  logic [NUM_MASTERS*ADDR_W-1:0] i_M_Addr;
  logic [NUM_MASTERS*4-1:0]      i_M_ByteEn;
  logic [NUM_MASTERS-1:0]        i_M_Read;
  logic [NUM_MASTERS-1:0]        i_M_Write;
  logic [NUM_MASTERS*32-1:0]     i_M_WriteData;
  logic [NUM_MASTERS*8-1:0]      i_M_BurstCount;
  logic [31:0]                   o_M_ReadData;
  logic [NUM_MASTERS-1:0]        o_M_WaitRequest;

  logic [ADDR_W-1:0]             o_S_Addr;
  logic [3:0]                    o_S_ByteEn;
  logic [31:0]                   o_S_WriteData;
  logic                          o_S_Read;
  logic                          o_S_Write;
  logic [31:0]                   i_S_ReadData;
  logic                          i_S_WaitRequest;

  logic [NUM_MASTERS-1:0]        o_Grant;
  logic                          o_Busy;

  // Arbiter side: the arbiter is the slave of all masters.
  modport slave (
    input  i_M_Addr, i_M_ByteEn, i_M_Read, i_M_Write,
    input  i_M_WriteData, i_M_BurstCount,
    input  i_S_ReadData, i_S_WaitRequest,
    output o_M_ReadData, o_M_WaitRequest,
    output o_S_Addr, o_S_ByteEn, o_S_WriteData,
    output o_S_Read, o_S_Write,
    output o_Grant, o_Busy
  );

  // Environment side: drives masters and the shared slave.
  modport master (
    output i_M_Addr, i_M_ByteEn, i_M_Read, i_M_Write,
    output i_M_WriteData, i_M_BurstCount,
    output i_S_ReadData, i_S_WaitRequest,
    input  o_M_ReadData, o_M_WaitRequest,
    input  o_S_Addr, o_S_ByteEn, o_S_WriteData,
    input  o_S_Read, o_S_Write,
    input  o_Grant, o_Busy
  );
endinterface

// File: rtl/avalon_bus_arbiter.sv
// Round-robin arbiter sharing one wait-request slave port
// between NUM_MASTERS masters; grant held for a whole burst.
module avalon_bus_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_W      = 30
) (
  input  logic i_Clk,
  input  logic i_Reset,
  avalon_bus_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_MASTERS);
  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(NUM_MASTERS - 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  logic [0:0]             state_q, state_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [IDX_W-1:0]       gidx_q, gidx_d;
  logic [7:0]             beats_q, beats_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;

  logic [NUM_MASTERS-1:0] req;
  logic                   sel_found;
  logic [IDX_W-1:0]       sel_idx;
  logic [7:0]             sel_bc;
  logic                   beat;
  logic                   rel;
  logic [IDX_W-1:0]       next_ptr;

  assign req = bus.i_M_Read | bus.i_M_Write;

  // First requester at or above ptr, wrapping around.
  always_comb begin
    int cand;
    cand      = 0;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      cand = (int'(ptr_q) + i) % NUM_MASTERS;
      if (!sel_found && req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(cand);
      end
    end
  end

  assign sel_bc = bus.i_M_BurstCount[sel_idx*8 +: 8];

  // Route the granted master to the slave; stall the rest.
  always_comb begin
    bus.o_S_Addr        = '0;
    bus.o_S_ByteEn      = '0;
    bus.o_S_WriteData   = '0;
    bus.o_S_Read        = 1'b0;
    bus.o_S_Write       = 1'b0;
    bus.o_M_WaitRequest = '1;
    if (state_q == S_GRANT) begin
      bus.o_S_Addr      = bus.i_M_Addr[gidx_q*ADDR_W +: ADDR_W];
      bus.o_S_ByteEn    = bus.i_M_ByteEn[gidx_q*4 +: 4];
      bus.o_S_WriteData = bus.i_M_WriteData[gidx_q*32 +: 32];
      bus.o_S_Read      = bus.i_M_Read[gidx_q];
      bus.o_S_Write     = bus.i_M_Write[gidx_q];
      bus.o_M_WaitRequest[gidx_q] = bus.i_S_WaitRequest;
    end
  end

  assign bus.o_M_ReadData = bus.i_S_ReadData;
  assign bus.o_Grant      = grant_q;
  assign bus.o_Busy       = (state_q == S_GRANT);

  assign beat = (bus.o_S_Read | bus.o_S_Write) &
                ~bus.i_S_WaitRequest;

  assign next_ptr = (gidx_q == LAST_IDX) ? '0
                  : gidx_q + 1'b1;

  // Release on the final beat or when the owner drops its request.
  assign rel = (state_q == S_GRANT) &&
               (!req[gidx_q] || (beat && beats_q == 8'd1));

  // Arbitration FSM next-state and burst counting.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    beats_d = beats_q;
    grant_d = grant_q;
    unique case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          state_d          = S_GRANT;
          gidx_d           = sel_idx;
          grant_d          = '0;
          grant_d[sel_idx] = 1'b1;
          beats_d = (sel_bc == 8'd0) ? 8'd1 : sel_bc;
        end
      end
      S_GRANT: begin
        if (beat && beats_q != 8'd0) begin
          beats_d = beats_q - 8'd1;
        end
        if (rel) begin
          state_d = S_IDLE;
          grant_d = '0;
          ptr_d   = next_ptr;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      beats_q <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      beats_q <= beats_d;
      grant_q <= grant_d;
    end
  end

endmodule
